// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared types and constants for the wide_add_seq slice.
//   state_t     - controller FSM states (IDLE, RUN, DONE)
//   CHUNK_DEF   - default shared-adder chunk width
//   NCHUNK_DEF  - default number of chunks
//   idx_w()     - width of the chunk index, never less than one bit
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNK_DEF  = 4;
    localparam int NCHUNK_DEF = 4;

    // A single chunk still needs a 1-bit index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational CHUNK-bit ripple-carry adder slice.
// Ports:
//   a, b  in  CHUNK  chunk operands
//   ci    in  1      carry in
//   sum   out CHUNK  chunk sum
//   co    out 1      carry out
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle wide adder. One CHUNK-bit adder is reused over
// NCHUNK cycles, least-significant chunk first, with the carry kept in cr.
// Optional feature macro: WIDE_ADD_SUB_EN adds the 'sub' port (x - y).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   x, y, c_in          operands and carry into chunk 0
//   sub                 subtract select, sampled at accept (macro only)
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   s, c_out            registered sum and carry out of the top chunk
//   busy                high in RUN or DONE
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int CHUNK  = CHUNK_DEF,
    parameter int NCHUNK = NCHUNK_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHUNK*NCHUNK-1:0] x,
    input  logic [CHUNK*NCHUNK-1:0] y,
    input  logic                    c_in,
`ifdef WIDE_ADD_SUB_EN
    input  logic                    sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHUNK*NCHUNK-1:0] s,
    output logic                    c_out,
    output logic                    busy
);

    localparam int W    = CHUNK * NCHUNK;
    localparam int IW   = idx_w(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t          state;
    logic [W-1:0]    xr;
    logic [W-1:0]    yr;
    logic            cr;
    logic [IW-1:0]   idx;

    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK-1:0] sum;
    logic             co;

    // Status outputs are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Chunk select as a constant-index mux so idx can never address
    // past the operand even when NCHUNK is not a power of two.
    always_comb begin
        a_chk = '0;
        b_chk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                a_chk = xr[k*CHUNK +: CHUNK];
                b_chk = yr[k*CHUNK +: CHUNK];
            end
        end
    end

    add_chunk #(.CHUNK(CHUNK)) u_add (
        .a   (a_chk),
        .b   (b_chk),
        .ci  (cr),
        .sum (sum),
        .co  (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            cr    <= 1'b0;
            idx   <= '0;
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr  <= x;
`ifdef WIDE_ADD_SUB_EN
                        // x - y = x + ~y + 1; c_in is overridden.
                        yr  <= sub ? ~y : y;
                        cr  <= sub ? 1'b1 : c_in;
`else
                        yr  <= y;
                        cr  <= c_in;
`endif
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k))
                            s[k*CHUNK +: CHUNK] <= sum;
                    end
                    cr <= co;
                    if (idx == LAST) begin
                        c_out <= co;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
